// File: rtl/soc_test_pkg.sv
// soc_test_pkg: shared states and constants for the directed-program test sequencer
package soc_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IMEM,
        LOAD_REGS,
        RUN,
        CHECK,
        DONE
    } state_e;

    localparam int          DEF_NUM_REGS    = 32;
    localparam int          DEF_RUN_TIMEOUT = 4096;
    localparam int          DEF_TO_W        = 13;
    localparam logic [31:0] PC_STEP         = 32'd4;

    function automatic logic is_busy(input state_e s);
        return !(s == IDLE || s == DONE);
    endfunction

endpackage

// File: rtl/soc_test_watchdog.sv
// soc_test_watchdog: RUN-phase cycle counter; expired flags the last allowed cycle
module soc_test_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int W       = 13
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + W'(1);
    end

    // Asserted during the TIMEOUT-th enabled cycle so exactly TIMEOUT cycles elapse
    assign o_expired = i_en && (r_count == W'(TIMEOUT - 1));
    assign o_count   = r_count;

endmodule

// File: rtl/soc_test_sequencer.sv
// soc_test_sequencer: loads a program and register image, runs the core, then checks registers
module soc_test_sequencer
    import soc_test_pkg::*;
#(
    parameter int IMEM_AW     = 8,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int RUN_TIMEOUT = DEF_RUN_TIMEOUT,
    parameter int TO_W        = DEF_TO_W
) (
    input  logic               Clk_Core,
    input  logic               Rst_Core_N,
    input  logic               Start,
    input  logic               Host_Valid,
    output logic               Host_Ready,
    input  logic [31:0]        Host_Data,
    input  logic               Host_Last,
    output logic               Core_Rst_N,
    input  logic [31:0]        Core_Pc,
    output logic               Imem_Wr_En,
    output logic [IMEM_AW-1:0] Imem_Wr_Addr,
    output logic [31:0]        Imem_Wr_Data,
    output logic               Reg_Wr_En,
    output logic [4:0]         Reg_Addr,
    output logic [31:0]        Reg_Wr_Data,
    input  logic [31:0]        Reg_Rd_Data,
    output logic               Busy,
    output logic               Done,
    output logic               Pass,
    output logic [5:0]         Fail_Count,
    output logic [4:0]         First_Fail,
    output logic               Timeout,
    output logic               Overflow
);

    state_e             r_state;
    state_e             w_next;
    logic [IMEM_AW:0]   r_cnt;
    logic [31:0]        r_target_pc;
    logic [4:0]         r_idx;
    logic               r_core_rst_n;
    logic               r_imem_wr_en;
    logic [IMEM_AW-1:0] r_imem_wr_addr;
    logic [31:0]        r_imem_wr_data;
    logic               r_reg_wr_en;
    logic [4:0]         r_reg_addr;
    logic [31:0]        r_reg_wr_data;
    logic [5:0]         r_fail_count;
    logic [4:0]         r_first_fail;
    logic               r_timeout;
    logic               r_overflow;
    logic               w_xfer;
    logic               w_run;
    logic               w_pc_hit;
    logic               w_expired;
    logic [TO_W-1:0]    w_run_cnt;

    soc_test_watchdog #(
        .TIMEOUT (RUN_TIMEOUT),
        .W       (TO_W)
    ) u_watchdog (
        .i_clk     (Clk_Core),
        .i_rst_n   (Rst_Core_N),
        .i_clr     (!w_run),
        .i_en      (w_run),
        .o_count   (w_run_cnt),
        .o_expired (w_expired)
    );

    assign w_run      = (r_state == RUN);
    assign w_xfer     = Host_Valid && Host_Ready;
    // The PC is still at its reset value in the first RUN cycle, so it is not trusted there
    assign w_pc_hit   = w_run && (w_run_cnt != '0) && (Core_Pc == r_target_pc);
    assign Host_Ready = (r_state == LOAD_IMEM) || (r_state == LOAD_REGS) || (r_state == CHECK);
    assign Busy       = is_busy(r_state);
    assign Done       = (r_state == DONE);
    assign Pass       = Done && (r_fail_count == '0) && !r_timeout && !r_overflow;

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = Start ? LOAD_IMEM : r_state;
            LOAD_IMEM:  w_next = (w_xfer && Host_Last) ? LOAD_REGS : r_state;
            LOAD_REGS:  w_next = (w_xfer && r_idx == 5'(NUM_REGS - 1)) ? RUN : r_state;
            RUN:        w_next = (w_pc_hit || w_expired) ? CHECK : r_state;
            CHECK:      w_next = (w_xfer && r_reg_addr == 5'(NUM_REGS - 1)) ? DONE : r_state;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            r_cnt          <= '0;
            r_target_pc    <= '0;
            r_idx          <= '0;
            r_core_rst_n   <= 1'b0;
            r_imem_wr_en   <= 1'b0;
            r_imem_wr_addr <= '0;
            r_imem_wr_data <= '0;
            r_reg_wr_en    <= 1'b0;
            r_reg_addr     <= '0;
            r_reg_wr_data  <= '0;
            r_fail_count   <= '0;
            r_first_fail   <= '0;
            r_timeout      <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_imem_wr_en <= 1'b0;
            r_reg_wr_en  <= 1'b0;
            r_core_rst_n <= (w_next == RUN);
            case (r_state)
                IDLE, DONE: begin
                    if (Start) begin
                        r_cnt        <= '0;
                        r_target_pc  <= '0;
                        r_idx        <= '0;
                        r_fail_count <= '0;
                        r_first_fail <= '0;
                        r_timeout    <= 1'b0;
                        r_overflow   <= 1'b0;
                    end
                end
                LOAD_IMEM: begin
                    if (w_xfer) begin
                        r_target_pc <= r_target_pc + PC_STEP;
                        if (r_cnt[IMEM_AW]) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_imem_wr_en   <= 1'b1;
                            r_imem_wr_addr <= r_cnt[IMEM_AW-1:0];
                            r_imem_wr_data <= Host_Data;
                            r_cnt          <= r_cnt + (IMEM_AW + 1)'(1);
                        end
                    end
                end
                LOAD_REGS: begin
                    if (w_xfer) begin
                        r_reg_wr_en   <= 1'b1;
                        r_reg_addr    <= r_idx;
                        r_reg_wr_data <= Host_Data;
                        r_idx         <= r_idx + 5'd1;
                    end
                end
                RUN: begin
                    r_reg_addr <= '0;
                    if (!w_pc_hit && w_expired)
                        r_timeout <= 1'b1;
                end
                CHECK: begin
                    if (w_xfer) begin
                        if (Host_Data != Reg_Rd_Data) begin
                            if (r_fail_count != 6'h3f)
                                r_fail_count <= r_fail_count + 6'd1;
                            if (r_fail_count == '0)
                                r_first_fail <= r_reg_addr;
                        end
                        r_reg_addr <= r_reg_addr + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Core_Rst_N   = r_core_rst_n;
    assign Imem_Wr_En   = r_imem_wr_en;
    assign Imem_Wr_Addr = r_imem_wr_addr;
    assign Imem_Wr_Data = r_imem_wr_data;
    assign Reg_Wr_En    = r_reg_wr_en;
    assign Reg_Addr     = r_reg_addr;
    assign Reg_Wr_Data  = r_reg_wr_data;
    assign Fail_Count   = r_fail_count;
    assign First_Fail   = r_first_fail;
    assign Timeout      = r_timeout;
    assign Overflow     = r_overflow;

endmodule

// File: tb/tb_soc_test_sequencer.sv
// tb_soc_test_sequencer: random programs on a toy core, scoreboarded against a reference model
module tb_soc_test_sequencer;

    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int TO = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       pass;
        logic       to;
        logic       ov;
        logic [5:0] fc;
        logic [4:0] ff;
        int         run;
    } res_t;

    logic clk = 0, rst_n = 0, start = 0, h_valid = 0, h_last = 0;
    logic [31:0] h_data = 0;
    logic h_ready, core_rst_n, imem_we, reg_we, busy, done, pass, timeout, overflow;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_data, reg_wdata, reg_rdata, core_pc;
    logic [4:0] reg_addr, first_fail;
    logic [5:0] fail_count;

    soc_test_sequencer #(.IMEM_AW(AW), .NUM_REGS(32), .RUN_TIMEOUT(TO), .TO_W(5)) dut (
        .Clk_Core(clk), .Rst_Core_N(rst_n), .Start(start), .Host_Valid(h_valid),
        .Host_Ready(h_ready), .Host_Data(h_data), .Host_Last(h_last), .Core_Rst_N(core_rst_n),
        .Core_Pc(core_pc), .Imem_Wr_En(imem_we), .Imem_Wr_Addr(imem_addr), .Imem_Wr_Data(imem_data),
        .Reg_Wr_En(reg_we), .Reg_Addr(reg_addr), .Reg_Wr_Data(reg_wdata), .Reg_Rd_Data(reg_rdata),
        .Busy(busy), .Done(done), .Pass(pass), .Fail_Count(fail_count), .First_Fail(first_fail),
        .Timeout(timeout), .Overflow(overflow)
    );

    always #5 clk = ~clk;

    // toy core: ADD rd,rs1,rs2 when bit31 set, otherwise NOP; PC frozen when stuck
    logic [31:0] core_imem [DEPTH] = '{default: 0};
    logic [31:0] core_rf [32] = '{default: 0};
    logic [31:0] pc_r = 0;
    logic [31:0] cur;
    logic stuck = 0;
    assign core_pc = pc_r;
    assign cur = core_imem[pc_r[AW+1:2]];
    assign reg_rdata = core_rf[reg_addr];

    always @(posedge clk) begin
        if (imem_we) core_imem[imem_addr] <= imem_data;
        if (reg_we && reg_addr != 0) core_rf[reg_addr] <= reg_wdata;
        if (!core_rst_n) pc_r <= 0;
        else if (!stuck) begin
            pc_r <= pc_r + 4;
            if (pc_r < 4 * DEPTH && cur[31] && cur[14:10] != 0)
                core_rf[cur[14:10]] <= core_rf[cur[9:5]] + core_rf[cur[4:0]];
        end
    end

    int checks = 0, failures = 0;
    wr_t imem_q[$], reg_q[$];
    res_t res_q[$];
    logic [31:0] prog[$];
    logic [31:0] init_rf [32];
    logic [31:0] sh_imem [DEPTH] = '{default: 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        failures++;
        $display("FAIL %s", msg);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a strobe or completes
    int run_cnt = 0;
    logic done_d = 0;
    wr_t mw;
    res_t mr;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            run_cnt = 0;
            done_d = 0;
        end else begin
            if (imem_we) begin
                if (imem_q.size() == 0) fail_now($sformatf("imem_unexpected addr %0d", imem_addr));
                else begin
                    mw = imem_q.pop_front();
                    check("imem_addr", 32'(imem_addr), mw.addr);
                    check("imem_data", imem_data, mw.data);
                end
            end
            if (reg_we) begin
                if (reg_q.size() == 0) fail_now($sformatf("reg_unexpected addr %0d", reg_addr));
                else begin
                    mw = reg_q.pop_front();
                    check("reg_addr", 32'(reg_addr), mw.addr);
                    check("reg_data", reg_wdata, mw.data);
                end
            end
            if (core_rst_n) run_cnt++;
            if (done && !done_d) begin
                if (res_q.size() == 0) fail_now("done_unexpected");
                else begin
                    mr = res_q.pop_front();
                    check("pass", 32'(pass), 32'(mr.pass));
                    check("timeout", 32'(timeout), 32'(mr.to));
                    check("overflow", 32'(overflow), 32'(mr.ov));
                    check("fail_count", 32'(fail_count), 32'(mr.fc));
                    check("first_fail", 32'(first_fail), 32'(mr.ff));
                    check("run_cycles", 32'(run_cnt), 32'(mr.run));
                end
                run_cnt = 0;
            end
            done_d = done;
        end
    end

    task automatic send(input logic [31:0] d, input logic last, input logic gaps, input logic noise);
        int g = 0;
        while (gaps && $urandom_range(0, 2) == 0) begin
            h_valid = 0;
            @(posedge clk); #1;
        end
        h_valid = 1; h_data = d; h_last = last;
        while (!h_ready && g < 100) begin
            start = noise && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            g++;
        end
        if (!h_ready) fail_now("ready_wait_expired");
        start = noise && ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        h_valid = 0; h_last = 0; start = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    function automatic logic [31:0] add_op(input int rd, input int rs1, input int rs2);
        return {1'b1, 16'd0, 5'(rd), 5'(rs1), 5'(rs2)};
    endfunction

    task automatic rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++)
            prog.push_back($urandom_range(0, 3) == 0 ? ($urandom() & 32'h7fff_ffff)
                : add_op($urandom_range(1, 30), $urandom_range(1, 30), $urandom_range(1, 30)));
    endtask

    task automatic rand_init();
        for (int r = 0; r < 32; r++) init_rf[r] = $urandom();
    endtask

    // reference: the core retires one word per cycle of release, i.e. words 0..target/4
    task automatic run_test(input logic stk, input logic gaps, input logic noise, input logic [31:0] bad);
        int n = prog.size();
        int run, fc, ff;
        logic to, ov;
        logic [31:0] ins;
        logic [31:0] m_rf [32];
        stuck = stk;
        for (int i = 0; i < n && i < DEPTH; i++) begin
            imem_q.push_back('{32'(i), prog[i]});
            sh_imem[i] = prog[i];
        end
        for (int r = 0; r < 32; r++) begin
            reg_q.push_back('{32'(r), init_rf[r]});
            m_rf[r] = (r == 0) ? 0 : init_rf[r];
        end
        ov = n > DEPTH;
        run = n + 1;
        to = stk || run > TO;
        if (to) run = TO;
        if (!stk)
            for (int j = 0; j < run && j < DEPTH; j++) begin
                ins = sh_imem[j];
                if (ins[31] && ins[14:10] != 0) m_rf[ins[14:10]] = m_rf[ins[9:5]] + m_rf[ins[4:0]];
            end
        fc = $countones(bad);
        ff = 0;
        for (int j = 31; j >= 0; j--) if (bad[j]) ff = j;
        res_q.push_back('{fc == 0 && !to && !ov, to, ov, 6'(fc), 5'(ff), run});
        pulse_start();
        for (int i = 0; i < n; i++) send(prog[i], i == n - 1, gaps, noise);
        for (int r = 0; r < 32; r++) send(init_rf[r], 1'($urandom_range(0, 1)), gaps, noise);
        for (int r = 0; r < 32; r++) send(m_rf[r] ^ {31'd0, bad[r]}, 1'($urandom_range(0, 1)), gaps, noise);
        for (int g = 0; g < 50 && !done; g++) begin
            @(posedge clk); #1;
        end
        if (!done) fail_now("done_wait_expired");
        repeat (3) @(posedge clk);
        #1;
        check("done_hold", 32'(done), 32'd1);
        check("pass_hold", 32'(pass), 32'(fc == 0 && !to && !ov));
    endtask

    task automatic check_reset();
        check("rst_core_rst_n", 32'(core_rst_n), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_reg_we", 32'(reg_we), 0);
        check("rst_host_ready", 32'(h_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_fail_count", 32'(fail_count), 0);
        check("rst_first_fail", 32'(first_fail), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
    endtask

    initial begin
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;

        // ADD x3 = x1 + x2 with x1=5, x2=7, then the same run with x3 and x5 expected wrong
        prog.delete();
        prog.push_back(add_op(3, 1, 2));
        prog.push_back(32'h0000_0001);
        prog.push_back(32'h0000_0002);
        rand_init();
        init_rf[1] = 5;
        init_rf[2] = 7;
        run_test(0, 0, 0, 32'h0);
        run_test(0, 0, 0, 32'h0000_0028);

        rand_prog(3); rand_init();
        run_test(1, 0, 0, 32'h0);

        rand_prog(4); rand_init();
        run_test(0, 1, 1, 32'h0);

        rand_prog(6); rand_init();
        run_test(0, 1, 0, 32'h0);

        // abort partway through the register image
        rand_prog(3); rand_init();
        stuck = 0;
        for (int i = 0; i < 3; i++) begin
            imem_q.push_back('{32'(i), prog[i]});
            sh_imem[i] = prog[i];
        end
        for (int r = 0; r < 9; r++) reg_q.push_back('{32'(r), init_rf[r]});
        pulse_start();
        for (int i = 0; i < 3; i++) send(prog[i], i == 2, 1, 0);
        for (int r = 0; r < 10; r++) send(init_rf[r], 0, 1, 0);
        rst_n = 0;
        #1;
        check_reset();
        @(posedge clk); #1;
        rst_n = 1;
        rand_prog(2); rand_init();
        run_test(0, 1, 1, 32'h0);

        for (int t = 0; t < 6; t++) begin
            rand_prog($urandom_range(1, 6));
            rand_init();
            run_test($urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) == 0 ? 32'h0 : (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31)));
        end

        check("imem_q_left", imem_q.size(), 0);
        check("reg_q_left", reg_q.size(), 0);
        check("res_q_left", res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_test_sequencer.md
Name: soc_test_sequencer

Overview:
Single-clock controller that runs one directed program on the core end to end. It holds the core in reset while streaming a program into instruction memory and initial values into the register file. It then releases the core and waits until the PC reaches the end of the program or a timeout expires. Finally it reads back all registers, compares them against a streamed expected list, and reports pass/fail. It sits beside soc_top as the self-checking test engine for running instruction regression programs back to back.

Parameters:
IMEM_AW, 8, instruction memory word-address width (depth 2^IMEM_AW)
NUM_REGS, 32, register count loaded and checked
RUN_TIMEOUT, 4096, max RUN cycles before abort
TO_W, 13, timeout counter width (must hold RUN_TIMEOUT)

Ports:
Clk_Core  in  1  core clock, rising edge
Rst_Core_N  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse, begins sequence (ignored unless IDLE/DONE)
Host_Valid  in  1  host word valid
Host_Ready  out  1  controller accepts word
Host_Data  in  32  program / init / expected word
Host_Last  in  1  marks final program word (LOAD_IMEM only)
Core_Rst_N  out  1  core reset, active low
Core_Pc  in  32  core program counter
Imem_Wr_En  out  1  instruction memory write strobe
Imem_Wr_Addr  out  IMEM_AW  word address
Imem_Wr_Data  out  32  instruction word
Reg_Wr_En  out  1  register file debug write strobe
Reg_Addr  out  5  register debug address (write and read)
Reg_Wr_Data  out  32  register write data
Reg_Rd_Data  in  32  combinational register read data at Reg_Addr
Busy  out  1  high outside IDLE/DONE
Done  out  1  high in DONE
Pass  out  1  valid when Done: no mismatches, no timeout, no overflow
Fail_Count  out  6  number of register mismatches
First_Fail  out  5  index of first mismatch (0 if none)
Timeout  out  1  RUN aborted by timeout
Overflow  out  1  program longer than 2^IMEM_AW words

Behaviour:
- Transfer = Host_Valid & Host_Ready sampled at rising edge.
- Reset (async): state IDLE. Core_Rst_N=0. All strobes 0. Host_Ready=0. Counters, Fail_Count, First_Fail, Timeout, Overflow, Pass, Done all 0.
- IDLE/DONE, Start -> LOAD_IMEM next cycle. Word count, flags and fail stats clear on that edge.
- LOAD_IMEM:
  - Host_Ready=1.
  - Each transfer registers Imem_Wr_En=1, Addr=count, Data=Host_Data one cycle later; count+1.
  - Count reaching 2^IMEM_AW: further writes suppressed, Overflow=1, count saturates.
  - Transfer with Host_Last -> LOAD_REGS.
  - target_pc = (words accepted incl. last) x 4, 32-bit, unsaturated.
- LOAD_REGS:
  - Host_Ready=1.
  - Transfer i (0..NUM_REGS-1) registers Reg_Wr_En=1, Reg_Addr=i, Reg_Wr_Data one cycle later. Register 0 is written; the regfile ignores it.
  - After transfer NUM_REGS-1 -> RUN. Host_Last is ignored.
- RUN:
  - Host_Ready=0. Core_Rst_N=1 registered, rising on first RUN cycle.
  - Timeout counter increments each RUN cycle.
  - Core_Pc==target_pc, sampled from the second RUN cycle onward -> CHECK.
  - Counter reaching RUN_TIMEOUT first -> Timeout=1, CHECK.
  - Both in same cycle: PC match wins, Timeout=0.
- CHECK:
  - Core_Rst_N=0 from first CHECK cycle. Core reset does not clear the register file.
  - Reg_Addr=index (registered), Host_Ready=1.
  - On transfer: Host_Data != Reg_Rd_Data -> Fail_Count+1 (saturate 63); First_Fail latched on first mismatch only.
  - index+1; after index NUM_REGS-1 -> DONE.
- DONE: Done=1, Pass=(Fail_Count==0 & !Timeout & !Overflow). Results hold until next Start.
- Start outside IDLE/DONE ignored. Reset mid-operation aborts immediately; partial memory contents are left as is.
- No write strobe is ever high in RUN, CHECK or DONE.

Decomposition:
- Package soc_test_pkg: state enum (IDLE, LOAD_IMEM, LOAD_REGS, RUN, CHECK, DONE), NUM_REGS, RUN_TIMEOUT default, PC_STEP=4.
- One sub-module, soc_test_watchdog: timeout counter with clear/enable and expired output.

Test Plan:
- 3-word ADD program, 32 init words, regfile model computing x3=x1+x2 (x1=5, x2=7), expected x3=12 -> Imem addrs 0,1,2 written; target_pc=12; Done=1, Pass=1, Fail_Count=0.
- Same run, expected x3=13 and x5 wrong -> Fail_Count=2, First_Fail=3, Pass=0.
- Core_Pc stuck at 0, RUN_TIMEOUT=16 -> exactly 16 RUN cycles, Timeout=1, CHECK still consumes 32 words, Pass=0.
- Host_Valid toggled 1-0-1 with gaps during all load phases -> write strobes only on transfer cycles, addresses contiguous 0..N-1.
- IMEM_AW=2, 6 program words -> only addrs 0..3 written, Overflow=1, target_pc=24, Pass=0.
- Reset asserted mid-LOAD_REGS after 10 words -> outputs at reset values same instant; new Start restarts at LOAD_IMEM with Imem_Wr_Addr=0.
